// File: rtl/main_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_pkg
// Brief    : Shared types and constants for the main-memory responder:
//            FSM state enum, request-kind enum, counter width and the
//            out-of-range address helper.
// Revision : 1.0 - initial release
// ============================================================================
package main_mem_pkg;

    // Responder transaction phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } main_mem_state_t;

    // Kind of request latched in IDLE
    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } main_mem_req_t;

    // Wait counter covers WAIT_CYCLES up to 255
    localparam int unsigned c_wcnt_w = 8;

    // True when any address bit at or above the implemented width is set
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned aw);
        return (aw >= 32) ? 1'b0 : ((addr >> aw) != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_mem_ram.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_ram
// Brief    : Single-port word memory, 2**ADDR_W x 32 bits. Synchronous
//            write, registered (read-first) read through the same address.
// Revision : 1.0 - initial release
// ============================================================================
module main_mem_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    // Storage array and read register; contents are never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_responder
// Brief    : Responder end of the main-memory valid/ready protocol.
//            IDLE -> WAIT (WAIT_CYCLES+1 cycles) -> RESP (one-cycle ready).
//            Writes have priority over reads raised in the same cycle.
//            Optional macro MAIN_MEM_RANGE_CHECK_EN: accesses with address
//            bits above ADDR_W are suppressed and flag a sticky err;
//            otherwise such addresses wrap and err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] main_mem_in_addr,
    input  logic [31:0] main_mem_in_data,
    input  logic        main_mem_in_valid,
    output logic        main_mem_in_ready,
    input  logic [31:0] main_mem_out_addr,
    input  logic        main_mem_out_valid,
    output logic [31:0] main_mem_out_data,
    output logic        main_mem_out_ready,
    output logic        err
);

    localparam logic [c_wcnt_w-1:0] c_wait_init = c_wcnt_w'(WAIT_CYCLES);
    localparam logic [c_wcnt_w-1:0] c_wcnt_one  = c_wcnt_w'(1);

    main_mem_state_t     r_state;
    main_mem_state_t     w_state_nxt;
    main_mem_req_t       r_kind;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_out_data;
    logic [c_wcnt_w-1:0] r_wcnt;

    logic                w_start;
    logic                w_wait_done;
    logic                w_in_ready;
    logic                w_out_ready;
    logic                w_addr_bad;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [31:0]         w_ram_rdata;

    // Next-state decode and the raw per-state handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wait_done = 1'b0;
        w_in_ready  = 1'b0;
        w_out_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (main_mem_in_valid || main_mem_out_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_wcnt == '0) begin
                    w_wait_done = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_in_ready  = (r_kind == REQ_WR);
                w_out_ready = (r_kind == REQ_RD);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the request in IDLE (write wins) and run the wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kind  <= REQ_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wcnt  <= '0;
        end else if (w_start) begin
            r_wcnt <= c_wait_init;
            if (main_mem_in_valid) begin
                r_kind  <= REQ_WR;
                r_addr  <= main_mem_in_addr;
                r_wdata <= main_mem_in_data;
            end else begin
                r_kind <= REQ_RD;
                r_addr <= main_mem_out_addr;
            end
        end else if ((r_state == WAIT) && (r_wcnt != '0)) begin
            r_wcnt <= r_wcnt - c_wcnt_one;
        end
    end

    // Capture read data on entry to RESP; held until the next read response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data <= '0;
        end else if (w_wait_done && (r_kind == REQ_RD)) begin
            r_out_data <= w_addr_bad ? 32'd0 : w_ram_rdata;
        end
    end

`ifdef MAIN_MEM_RANGE_CHECK_EN
    logic r_err;

    assign w_addr_bad = addr_out_of_range(r_addr, ADDR_W);

    // Sticky flag raised when an out-of-range access completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (r_state == RESP) begin
            r_err <= r_err | w_addr_bad;
        end
    end

    assign err = r_err;
`else
    assign w_addr_bad = 1'b0;
    assign err        = 1'b0;
`endif

    // In IDLE the RAM reads the incoming address so data is ready one cycle
    // into WAIT; afterwards only the latched address is used. Upper address
    // bits are dropped by the cast, giving wrap-around.
    assign w_ram_addr = (r_state != IDLE)  ? ADDR_W'(r_addr) :
                        main_mem_in_valid  ? ADDR_W'(main_mem_in_addr) :
                                             ADDR_W'(main_mem_out_addr);

    // Reset during RESP aborts: no commit and no ready
    assign w_ram_we = w_in_ready & ~w_addr_bad & ~reset;

    assign main_mem_in_ready  = w_in_ready  & ~reset;
    assign main_mem_out_ready = w_out_ready & ~reset;
    assign main_mem_out_data  = reset ? 32'd0 : r_out_data;

    main_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_mem_responder
// Brief    : Self-checking bench for main_mem_responder. Instance 0 uses
//            WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0. Expected data
//            comes from a word-addressed associative-array memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_mem_responder;

`ifdef MAIN_MEM_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0][31:0] in_addr;
    logic [1:0][31:0] in_data;
    logic [1:0][31:0] out_addr;
    logic [1:0]       in_valid;
    logic [1:0]       out_valid;
    wire  [1:0]       in_ready;
    wire  [1:0]       out_ready;
    wire  [1:0]       err;
    wire  [1:0][31:0] out_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [int unsigned];
    bit   [1:0]  err_m;
    bit   [1:0]  prev_rdy;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    main_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(2)) u_dut (
        .clk                (clk),
        .reset              (reset),
        .main_mem_in_addr   (in_addr[0]),
        .main_mem_in_data   (in_data[0]),
        .main_mem_in_valid  (in_valid[0]),
        .main_mem_in_ready  (in_ready[0]),
        .main_mem_out_addr  (out_addr[0]),
        .main_mem_out_valid (out_valid[0]),
        .main_mem_out_data  (out_data[0]),
        .main_mem_out_ready (out_ready[0]),
        .err                (err[0])
    );

    main_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk                (clk),
        .reset              (reset),
        .main_mem_in_addr   (in_addr[1]),
        .main_mem_in_data   (in_data[1]),
        .main_mem_in_valid  (in_valid[1]),
        .main_mem_in_ready  (in_ready[1]),
        .main_mem_out_addr  (out_addr[1]),
        .main_mem_out_valid (out_valid[1]),
        .main_mem_out_data  (out_data[1]),
        .main_mem_out_ready (out_ready[1]),
        .err                (err[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return RANGE_ON && (a[31:16] != 16'h0);
    endfunction

    function automatic int unsigned key(input int d, input logic [31:0] a);
        return (d * 65536) + int'(a[15:0]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete handshake; returns read data and cycles until ready
    task automatic txn(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        rd   = '0;
        if (wr) begin
            in_addr[d]  = a;
            in_data[d]  = wd;
            in_valid[d] = 1'b1;
        end else begin
            out_addr[d]  = a;
            out_valid[d] = 1'b1;
        end
        while (!seen && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (wr ? in_ready[d] : out_ready[d]) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout: dut%0d wr=%0d addr %h got no ready, expected one", d, wr, a);
        end
        rd = out_data[d];
        in_valid[d]  = 1'b0;
        out_valid[d] = 1'b0;
        chk($sformatf("latency dut%0d wr=%0d", d, wr), 32'(lat), 32'(wait_of(d) + 2));
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(wr ? in_ready[d] : out_ready[d]), 32'd0);
        if (!wr) chk("rd_hold", out_data[d], rd);
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] v);
        logic [31:0] rd;
        int lat;
        txn(d, 1'b1, a, v, rd, lat);
        if (!oor(a)) mdl[key(d, a)] = v;
        if (oor(a)) err_m[d] = 1'b1;
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input string nm);
        logic [31:0] rd;
        logic [31:0] exp;
        int lat;
        txn(d, 1'b0, a, 32'd0, rd, lat);
        if (oor(a)) begin
            exp = 32'd0;
            err_m[d] = 1'b1;
        end else begin
            exp = mdl.exists(key(d, a)) ? mdl[key(d, a)] : 32'd0;
        end
        chk(nm, rd, exp);
    endtask

    // Ready rules: never both at once, never on consecutive cycles
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            total++;
            if (in_ready[d] && out_ready[d]) begin
                bad++;
                $display("FAIL both_ready dut%0d: got 1 expected 0", d);
            end
            total++;
            if (prev_rdy[d] && (in_ready[d] || out_ready[d])) begin
                bad++;
                $display("FAIL consecutive_ready dut%0d: got 1 expected 0", d);
            end
            prev_rdy[d] = in_ready[d] | out_ready[d];
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int lat;
        int d;
        int wc;
        int rc;
        int c;
        int n;

        in_addr   = '0;
        in_data   = '0;
        out_addr  = '0;
        in_valid  = '0;
        out_valid = '0;
        err_m     = '0;
        prev_rdy  = '0;

        vt[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        vt[2] = '{1'b1, 32'h30, 32'hA0A0A0A0, 32'h0};
        vt[3] = '{1'b1, 32'h05, 32'h0BADF00D, 32'h0};
        vt[4] = '{1'b0, 32'h30, 32'h0,        32'hA0A0A0A0};
        vt[5] = '{1'b1, 32'h10, 32'hCAFEF00D, 32'h0};
        vt[6] = '{1'b0, 32'h10, 32'h0,        32'hCAFEF00D};
        vt[7] = '{1'b0, 32'h05, 32'h0,        32'h0BADF00D};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_in_ready%0d", i),  32'(in_ready[i]),  32'd0);
            chk($sformatf("rst_out_ready%0d", i), 32'(out_ready[i]), 32'd0);
            chk($sformatf("rst_out_data%0d", i),  out_data[i],       32'd0);
            chk($sformatf("rst_err%0d", i),       32'(err[i]),       32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table on the WAIT_CYCLES=2 instance
        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) begin
                do_write(0, vt[i].addr, vt[i].data);
            end else begin
                txn(0, 1'b0, vt[i].addr, 32'd0, rd, lat);
                chk($sformatf("table_rd%0d", i), rd, vt[i].exp);
            end
        end

        // Read data holds across an intervening write
        do_write(0, 32'h40, 32'h00000011);
        chk("rd_hold_across_wr", out_data[0], 32'h0BADF00D);

        // Simultaneous write and read: write served first
        in_addr[0]   = 32'h20;
        in_data[0]   = 32'h1234;
        in_valid[0]  = 1'b1;
        out_addr[0]  = 32'h20;
        out_valid[0] = 1'b1;
        wc = 0;
        rc = 0;
        c  = 0;
        rd = '0;
        while (rc == 0 && c < 300) begin
            @(posedge clk); #1;
            c++;
            if (in_ready[0]) begin
                wc = c;
                in_valid[0] = 1'b0;
            end
            if (out_ready[0]) begin
                rc = c;
                rd = out_data[0];
                out_valid[0] = 1'b0;
            end
        end
        in_valid[0]  = 1'b0;
        out_valid[0] = 1'b0;
        mdl[key(0, 32'h20)] = 32'h1234;
        chk("simul_wr_cycle", 32'(wc), 32'(wait_of(0) + 2));
        chk("simul_rd_cycle", 32'(rc), 32'(2 * (wait_of(0) + 2) + 1));
        chk("simul_rd_data", rd, 32'h1234);
        @(posedge clk); #1;

        // Reset during WAIT aborts the write
        in_addr[0]  = 32'h30;
        in_data[0]  = 32'h5555;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid[0] = 1'b0;
        chk("abort_ready_in_reset", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        chk("abort_out_data_in_reset", out_data[0], 32'd0);
        reset = 1'b0;
        err_m = '0;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            n += int'(in_ready[0]) + int'(out_ready[0]);
        end
        chk("abort_no_ready", 32'(n), 32'd0);
        do_read(0, 32'h30, "abort_keeps_old");

        // Back-to-back reads with zero wait states
        do_write(1, 32'h1, 32'hAAAA0001);
        do_write(1, 32'h2, 32'hAAAA0002);
        do_read(1, 32'h1, "b2b_rd1");
        do_read(1, 32'h2, "b2b_rd2");
        do_read(1, 32'h1, "b2b_rd3");

        // Address above ADDR_W: suppressed with range check, wraps otherwise
        do_write(0, 32'h00010005, 32'h77778888);
        chk("oor_err", 32'(err[0]), 32'(err_m[0]));
        do_read(0, 32'h00000005, "oor_low_word");
        do_read(0, 32'h00010005, "oor_rd");
        chk("oor_err_sticky", 32'(err[0]), 32'(err_m[0]));

        // Random traffic against the model
        for (int i = 0; i < 16; i++) begin
            do_write(0, 32'h100 + i, $urandom());
            do_write(1, 32'h100 + i, $urandom());
        end
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            a = 32'h100 + $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) a = a | 32'h00020000;
            if ($urandom_range(0, 1) == 1) begin
                do_write(d, a, $urandom());
            end else begin
                do_read(d, a, "rand_rd");
            end
            chk("rand_err", 32'(err[d]), 32'(err_m[d]));
        end

        // Reset clears err but keeps memory
        reset = 1'b1;
        @(posedge clk); #1;
        chk("final_rst_err0", 32'(err[0]), 32'd0);
        chk("final_rst_err1", 32'(err[1]), 32'd0);
        reset = 1'b0;
        err_m = '0;
        @(posedge clk); #1;
        do_read(0, 32'h10, "mem_after_reset");
        do_read(1, 32'h2, "mem_after_reset_w0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: word-address bits implemented; depth 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response, range 0..255.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports main_mem_in_addr  in  32  write word address; main_mem_in_data  in  32  write data; main_mem_in_valid  in  1  write request; main_mem_in_ready  out  1  write-done pulse.
REQ-006 SHALL have ports main_mem_out_addr  in  32  read word address; main_mem_out_valid  in  1  read request; main_mem_out_data  out  32  read data; main_mem_out_ready  out  1  read-done pulse.
REQ-007 SHALL have port err  out  1  sticky out-of-range flag, present only per REQ-024.

Function
REQ-008 SHALL be the responder end of the main-memory valid/ready protocol: the initiator holds valid, addr and data stable until it samples ready=1, then drops valid on the next edge.
REQ-009 SHALL implement the state machine IDLE -> WAIT -> RESP -> IDLE.
REQ-010 IDLE SHALL sample the requests each cycle; on a pending request, latch its address (plus data for writes) and the request kind, load the wait counter with WAIT_CYCLES and go to WAIT; with no request pending, remain in IDLE.
REQ-011 WAIT SHALL decrement the counter and go to RESP the cycle after it reaches 0, so WAIT_CYCLES=0 spends exactly one cycle in WAIT.
REQ-012 Latency: a request first seen in IDLE at cycle T SHALL get ready asserted at cycle T+2+WAIT_CYCLES.
REQ-013 RESP SHALL last exactly one cycle: assert the matching ready (in_ready for writes, out_ready for reads) for that cycle only, then return to IDLE.
REQ-014 A write SHALL commit main_mem_in_data to the latched address at the RESP edge.
REQ-015 For a read, main_mem_out_data SHALL be registered on entry to RESP, stay valid during the ready cycle, and hold that value until the next read response.
REQ-016 When both in_valid and out_valid are high in IDLE, the write SHALL be served first; the read SHALL be served on the following IDLE visit.
REQ-017 A read served immediately after a write to the same address SHALL return the newly written data.
REQ-018 in_ready and out_ready SHALL never be high in the same cycle and never high on two consecutive cycles.
REQ-019 The responder SHALL use only the latched copies of addr and data after IDLE, ignoring any later input changes.
REQ-020 Address bits above ADDR_W SHALL be handled per REQ-024 and REQ-025.

Reset
REQ-021 While reset is high, the block SHALL be in IDLE with in_ready=0, out_ready=0, main_mem_out_data=0, wait counter=0 and err=0.
REQ-022 Reset asserted during WAIT or RESP SHALL abort the transaction: no write commits, no ready is issued, and the state returns to IDLE.
REQ-023 Reset SHALL NOT clear memory contents.

Configuration
REQ-024 With MAIN_MEM_RANGE_CHECK_EN defined, an access with any address bit [31:ADDR_W] set SHALL still complete with normal latency, but a write SHALL not commit, a read SHALL return 0, and err SHALL be set to 1 and held until reset.
REQ-025 Without MAIN_MEM_RANGE_CHECK_EN, address bits above ADDR_W SHALL be ignored so that addresses wrap, and err SHALL be tied to 0.

Structure
REQ-026 The state enum (IDLE, WAIT, RESP) and the request-kind enum (REQ_RD, REQ_WR) SHALL reside in the shared package main_mem_pkg.
REQ-027 Storage SHALL be a single sub-module main_mem_ram: single-port, synchronous write, registered read, parameterised by ADDR_W.

Verification
REQ-028 With WAIT_CYCLES=2, write 0xDEADBEEF to address 0x10 with in_valid at cycle 0 -> in_ready=1 only at cycle 4.
REQ-029 Then read address 0x10 -> out_ready is a one-cycle pulse with out_data=0xDEADBEEF.
REQ-030 Raise a write (addr 0x20, 0x1234) and a read (addr 0x20) in the same cycle -> in_ready precedes out_ready, and the read returns 0x1234.
REQ-031 Assert reset during WAIT of a write of 0x5555 to addr 0x30 -> no ready is issued; a later read of 0x30 returns the prior contents.
REQ-032 With WAIT_CYCLES=0, back-to-back reads -> each ready arrives 2 cycles after its valid, and ready is never high on two consecutive cycles.
REQ-033 With MAIN_MEM_RANGE_CHECK_EN and ADDR_W=16, write to 0x00010005 -> completes, err=1, and address 0x0005 is unchanged; without the macro, the same write lands at 0x0005 and err=0.
